// File: rtl/riscv_pc_pkg.sv
// Shared types for the next-PC sequencer.
// State encoding, select codes and PC increment.
package riscv_pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [2:0] {
    SEL_RST  = 3'd0,
    SEL_SEQ  = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_BR   = 3'd3,
    SEL_HOLD = 3'd4
  } sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC data mux with the sequential +4 adder.
// Pure combinational; select code comes from the sequencer.
module pc_next_mux
  import riscv_pc_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter logic [N-1:0] RESET_VEC = '0
) (
  input  sel_t         sel,
  input  logic [N-1:0] pc_q,
  input  logic [N-1:0] br_tgt,
  input  logic [N-1:0] jmp_tgt,
  output logic [N-1:0] pc_data
);

  logic [N-1:0] pc_seq;

  assign pc_seq = pc_q + N'(PC_INC);

  // select the next fetch address
  always_comb begin
    pc_data = pc_q;
    unique case (sel)
      SEL_RST:  pc_data = RESET_VEC;
      SEL_SEQ:  pc_data = pc_seq;
      SEL_JMP:  pc_data = jmp_tgt;
      SEL_BR:   pc_data = br_tgt;
      SEL_HOLD: pc_data = pc_q;
      default:  pc_data = pc_q;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for fetch: boot, run, halt,
// redirect priority, misalign trap and redirect count.
module pc_sequencer
  import riscv_pc_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter logic [N-1:0] RESET_VEC = '0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     pc_q_i,
  input  logic             stall_i,
  input  logic             branch_take_i,
  input  logic [N-1:0]     branch_tgt_i,
  input  logic             jump_i,
  input  logic [N-1:0]     jump_tgt_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             pc_load_o,
  output logic [N-1:0]     pc_data_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  sel_t   sel;
  logic   redir_ok;
  logic   mis_ev;

  // next-PC source selection by state and priority
  always_comb begin
    sel       = SEL_HOLD;
    pc_load_o = 1'b0;
    flush_o   = 1'b0;
    redir_ok  = 1'b0;
    mis_ev    = 1'b0;
    if (reset) begin
      sel       = SEL_RST;
      pc_load_o = 1'b1;
      flush_o   = 1'b1;
    end else begin
      unique case (state)
        BOOT: begin
          sel       = SEL_RST;
          pc_load_o = 1'b1;
          flush_o   = 1'b1;
        end
        RUN: begin
          if (halt_i) begin
            sel = SEL_HOLD;
          end else if (jump_i) begin
            if (jump_tgt_i[1:0] != 2'b00) begin
              mis_ev = 1'b1;
            end else begin
              sel       = SEL_JMP;
              pc_load_o = 1'b1;
              flush_o   = 1'b1;
              redir_ok  = 1'b1;
            end
          end else if (branch_take_i) begin
            if (branch_tgt_i[1:0] != 2'b00) begin
              mis_ev = 1'b1;
            end else begin
              sel       = SEL_BR;
              pc_load_o = 1'b1;
              flush_o   = 1'b1;
              redir_ok  = 1'b1;
            end
          end else if (stall_i) begin
            sel = SEL_HOLD;
          end else begin
            sel       = SEL_SEQ;
            pc_load_o = 1'b1;
          end
        end
        HALT: sel = SEL_HOLD;
        default: begin
          sel       = SEL_RST;
          pc_load_o = 1'b1;
          flush_o   = 1'b1;
        end
      endcase
    end
  end

  pc_next_mux #(
    .N         (N),
    .RESET_VEC (RESET_VEC)
  ) u_mux (
    .sel     (sel),
    .pc_q    (pc_q_i),
    .br_tgt  (branch_tgt_i),
    .jmp_tgt (jump_tgt_i),
    .pc_data (pc_data_o)
  );

  // FSM plus registered status flags and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      halted_o       <= 1'b0;
      misalign_o     <= 1'b0;
      redirect_cnt_o <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (halt_i || mis_ev) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end
          if (mis_ev) begin
            misalign_o <= 1'b1;
          end
          if (redir_ok && (redirect_cnt_o != CNT_MAX)) begin
            redirect_cnt_o <= redirect_cnt_o + 1'b1;
          end
        end
        HALT: begin
          if (resume_i) begin
            state    <= RUN;
            halted_o <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
